// File: rtl/cache_pkg.sv
// Shared cache definitions: block geometry, fill controller state encoding
// and the block-offset mask used to align miss addresses to a block base.
package cache_pkg;

  // Words per cache block and bytes per 16-bit word.
  localparam int BLOCK_WORDS = 8;
  localparam int WORD_BYTES  = 2;

  // Byte-offset bits inside one block (0xF for 8 x 16-bit words).
  localparam int BLOCK_OFFSET_MASK = BLOCK_WORDS * WORD_BYTES - 1;

  // Miss-handling controller states.
  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  // Byte-offset mask for a block of the given number of words.
  function automatic int offset_mask(input int words);
    return words * WORD_BYTES - 1;
  endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Bus bundle between the fill controller, the cache arrays and main memory.
// master = the fill controller, slave = cache/memory side.
interface cache_fill_fsm_if #(
  parameter int ADDR_W = 16
);

  // Miss request from the cache and the pipeline stall back to it.
  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              fsm_busy;

  // Word request stream to memory and the in-order return stream.
  logic              memory_enable;
  logic [ADDR_W-1:0] memory_address;
  logic              memory_data_valid;
  logic [15:0]       memory_data;

  // Writes into the cache data and tag arrays.
  logic              write_data_array;
  logic [ADDR_W-1:0] fill_address;
  logic [15:0]       fill_data;
  logic              write_tag_array;

  modport master (
    input  miss_detected,
    input  miss_address,
    input  memory_data_valid,
    input  memory_data,
    output fsm_busy,
    output memory_enable,
    output memory_address,
    output write_data_array,
    output fill_address,
    output fill_data,
    output write_tag_array
  );

  modport slave (
    output miss_detected,
    output miss_address,
    output memory_data_valid,
    output memory_data,
    input  fsm_busy,
    input  memory_enable,
    input  memory_address,
    input  write_data_array,
    input  fill_address,
    input  fill_data,
    input  write_tag_array
  );

endinterface

// File: rtl/cache_fill_fsm_word_counter.sv
// Word counter for one block fill: synchronous clear, count enable,
// saturates at MAX_COUNT and flags terminal count when it gets there.
module word_counter
  import cache_pkg::*;
#(
  parameter  int MAX_COUNT = BLOCK_WORDS,
  localparam int CW        = $clog2(MAX_COUNT) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  logic [CW-1:0] count_reg;

  // Clear wins over enable; the count holds once it reaches MAX_COUNT.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && !tc) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign count = count_reg;
  assign tc    = (count_reg == CW'(MAX_COUNT));

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller. Accepts one miss at a time, stalls the
// pipeline, streams one word request per cycle for the whole block, writes
// every returned word into the data array in order and writes the tag with
// the last word. Memory latency is not timed, only returned words counted.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS,
  parameter int ADDR_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  cache_fill_fsm_if.master        bus
);

  localparam int CW          = $clog2(BLOCK_WORDS) + 1;
  localparam int OFFSET_MASK = offset_mask(BLOCK_WORDS);
  localparam int WORD_SHIFT  = $clog2(WORD_BYTES);
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(OFFSET_MASK);

  fill_state_t       state_reg;
  logic [ADDR_W-1:0] base_addr_reg;

  logic [CW-1:0]     issue_cnt;
  logic [CW-1:0]     recv_cnt;
  logic              issue_tc;
  logic              recv_tc;

  logic              in_fill;
  logic              accept;
  logic              issue_en;
  logic              recv_en;
  logic              last_word;
  logic [ADDR_W-1:0] issue_offset;
  logic [ADDR_W-1:0] recv_offset;

  // Miss accepted only from IDLE; misses during FILL are ignored and the
  // cache keeps miss_detected up until it is served.
  assign in_fill   = (state_reg == FILL);
  assign accept    = (state_reg == IDLE) && bus.miss_detected;

  // Returns while IDLE are stale (e.g. in flight across a reset) and dropped.
  assign issue_en  = in_fill && !issue_tc;
  assign recv_en   = in_fill && bus.memory_data_valid && !recv_tc;
  assign last_word = recv_en && (recv_cnt == CW'(BLOCK_WORDS - 1));

  // Byte offsets inside the block never exceed the offset mask, so adding
  // them to the aligned base cannot carry into the tag bits.
  assign issue_offset = ADDR_W'(issue_cnt) << WORD_SHIFT;
  assign recv_offset  = ADDR_W'(recv_cnt) << WORD_SHIFT;

  // Controller state and latched block base address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      base_addr_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.miss_detected) begin
            base_addr_reg <= bus.miss_address & BASE_MASK;
            state_reg     <= FILL;
          end
        end
        FILL: begin
          if (last_word) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Request counter: one word request per FILL cycle until the block is out.
  word_counter #(
    .MAX_COUNT (BLOCK_WORDS)
  ) u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (issue_en),
    .count (issue_cnt),
    .tc    (issue_tc)
  );

  // Return counter: advances on each returned word, in issue order.
  word_counter #(
    .MAX_COUNT (BLOCK_WORDS)
  ) u_recv_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (recv_en),
    .count (recv_cnt),
    .tc    (recv_tc)
  );

  // Stall starts in the acceptance cycle so the pipeline never runs past
  // the missing access.
  assign bus.fsm_busy         = in_fill || accept;

  assign bus.memory_enable    = issue_en;
  assign bus.memory_address   = base_addr_reg + issue_offset;

  assign bus.write_data_array = recv_en;
  assign bus.fill_address     = base_addr_reg + recv_offset;
  assign bus.fill_data        = bus.memory_data;
  assign bus.write_tag_array  = last_word;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: a memory model with fixed or
// irregular latency, and a scoreboard of expected requests and array writes.
module tb_cache_fill_fsm;

  logic clk;
  logic rst;

  cache_fill_fsm_if #(.ADDR_W(16)) bus ();

  cache_fill_fsm #(
    .BLOCK_WORDS (8),
    .ADDR_W      (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        last;
  } fill_exp_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [15:0] exp_req[$];
  fill_exp_t   exp_fill[$];

  int          pend_due[$];
  logic [15:0] pend_addr[$];
  int          last_due = 0;
  bit          irregular = 0;
  int          ret_cnt = 0;

  int req_cnt = 0;
  int req_first = -1;
  int req_last = -1;
  int wr_cnt = 0;
  int tag_cnt = 0;
  int tag_cycle = -1;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model, request side: capture each request and its return cycle.
  initial forever begin
    @(negedge clk);
    if (bus.memory_enable === 1'b1) begin
      int lat;
      int due;
      lat = irregular ? int'($urandom_range(7, 4)) : 4;
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_due.push_back(due);
      pend_addr.push_back(bus.memory_address);
    end
  end

  // Memory model, return side: one word per cycle, in request order.
  initial begin
    bus.memory_data_valid = 1'b0;
    bus.memory_data = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (pend_due.size() > 0 && pend_due[0] == cyc) begin
        bus.memory_data_valid = 1'b1;
        bus.memory_data = mem_word(pend_addr[0]);
        void'(pend_due.pop_front());
        void'(pend_addr.pop_front());
        ret_cnt++;
      end else begin
        bus.memory_data_valid = 1'b0;
        bus.memory_data = 16'($urandom);
      end
    end
  end

  // Scoreboard monitor: compares every request and array write as it appears.
  initial forever begin
    @(negedge clk);
    if (bus.memory_enable === 1'b1) begin
      checks++;
      if (exp_req.size() == 0) begin
        errors++;
        $display("FAIL unexpected_req cyc=%0d got addr=%h required none", cyc, bus.memory_address);
      end else begin
        logic [15:0] e;
        e = exp_req.pop_front();
        if (bus.memory_address !== e) begin
          errors++;
          $display("FAIL req_addr cyc=%0d got %h required %h", cyc, bus.memory_address, e);
        end
      end
      req_cnt++;
      if (req_first < 0) req_first = cyc;
      req_last = cyc;
    end
    if (bus.write_data_array === 1'b1) begin
      checks++;
      if (exp_fill.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write cyc=%0d got addr=%h data=%h required none", cyc, bus.fill_address, bus.fill_data);
      end else begin
        fill_exp_t f;
        f = exp_fill.pop_front();
        if (bus.fill_address !== f.addr || bus.fill_data !== f.data) begin
          errors++;
          $display("FAIL fill_write cyc=%0d got %h/%h required %h/%h", cyc, bus.fill_address, bus.fill_data, f.addr, f.data);
        end
        checks++;
        if (bus.write_tag_array !== f.last) begin
          errors++;
          $display("FAIL tag_with_word cyc=%0d got %b required %b", cyc, bus.write_tag_array, f.last);
        end
        $display("write cyc=%0d addr=%h data=%h tag=%b", cyc, bus.fill_address, bus.fill_data, bus.write_tag_array);
      end
      wr_cnt++;
    end else begin
      checks++;
      if (bus.write_tag_array !== 1'b0) begin
        errors++;
        $display("FAIL stray_tag cyc=%0d got %b required 0", cyc, bus.write_tag_array);
      end
    end
    if (bus.write_tag_array === 1'b1) begin
      tag_cnt++;
      tag_cycle = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got no finish required finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic clear_stats();
    req_cnt = 0;
    req_first = -1;
    req_last = -1;
    wr_cnt = 0;
    tag_cnt = 0;
    tag_cycle = -1;
  endtask

  task automatic push_block(input logic [15:0] base);
    for (int i = 0; i < 8; i++) begin
      logic [15:0] a;
      fill_exp_t f;
      a = base + 16'(2 * i);
      exp_req.push_back(a);
      f.addr = a;
      f.data = mem_word(a);
      f.last = (i == 7);
      exp_fill.push_back(f);
    end
  endtask

  // Raise a one-cycle miss; t returns the acceptance cycle.
  task automatic issue_miss(input logic [15:0] addr, output int t);
    @(posedge clk);
    #2;
    bus.miss_detected = 1'b1;
    bus.miss_address = addr;
    t = cyc;
    @(posedge clk);
    #2;
    bus.miss_detected = 1'b0;
  endtask

  task automatic wait_tags(input int n, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (tag_cnt >= n) break;
    end
    checks++;
    if (tag_cnt < n) begin
      errors++;
      $display("FAIL %s_timeout got tags=%0d required %0d", name, tag_cnt, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.miss_detected = 1'b0;
    bus.miss_address = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.fsm_busy, bus.memory_enable, bus.write_data_array, bus.write_tag_array} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got %b required 0000", {bus.fsm_busy, bus.memory_enable, bus.write_data_array, bus.write_tag_array});
    end
    checks++;
    if (bus.memory_address !== 16'h0000 || bus.fill_address !== 16'h0000) begin
      errors++;
      $display("FAIL reset_addr got %h/%h required 0000/0000", bus.memory_address, bus.fill_address);
    end
    checks++;
    if (bus.fill_data !== bus.memory_data) begin
      errors++;
      $display("FAIL fill_data_pass got %h required %h", bus.fill_data, bus.memory_data);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.fsm_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy got %b required 0", bus.fsm_busy);
    end
    $display("reset done cyc=%0d", cyc);
  endtask

  task automatic test_basic_fill();
    int t;
    int busy_len;
    clear_stats();
    push_block(16'h1230);
    @(posedge clk);
    #2;
    bus.miss_detected = 1'b1;
    bus.miss_address = 16'h1234;
    t = cyc;
    @(negedge clk);
    checks++;
    if (bus.fsm_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_on_accept got %b required 1", bus.fsm_busy);
    end
    busy_len = 1;
    @(posedge clk);
    #2;
    bus.miss_detected = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.fsm_busy !== 1'b1) break;
      busy_len++;
    end
    checks++;
    if (busy_len != 13) begin
      errors++;
      $display("FAIL busy_len got %0d required 13", busy_len);
    end
    @(posedge clk);
    #2;
    checks++;
    if (req_cnt != 8 || req_first != t + 1 || req_last != t + 8) begin
      errors++;
      $display("FAIL req_window got n=%0d %0d..%0d required n=8 %0d..%0d", req_cnt, req_first, req_last, t + 1, t + 8);
    end
    checks++;
    if (wr_cnt != 8 || tag_cnt != 1 || tag_cycle != t + 12) begin
      errors++;
      $display("FAIL fill_summary got w=%0d tags=%0d at %0d required w=8 tags=1 at %0d", wr_cnt, tag_cnt, tag_cycle, t + 12);
    end
    $display("basic fill miss=1234 t=%0d busy=%0d", t, busy_len);
  endtask

  task automatic test_top_of_memory();
    int t;
    clear_stats();
    push_block(16'hFFF0);
    issue_miss(16'hFFFE, t);
    wait_tags(1, 40, "top_fill");
    checks++;
    if (wr_cnt != 8 || req_cnt != 8 || exp_fill.size() != 0) begin
      errors++;
      $display("FAIL top_counts got w=%0d r=%0d left=%0d required 8/8/0", wr_cnt, req_cnt, exp_fill.size());
    end
    $display("top-of-memory fill miss=FFFE t=%0d", t);
  endtask

  task automatic test_miss_held();
    int t;
    clear_stats();
    push_block(16'h2000);
    push_block(16'h4000);
    @(posedge clk);
    #2;
    bus.miss_detected = 1'b1;
    bus.miss_address = 16'h2000;
    t = cyc;
    @(posedge clk);
    #2;
    bus.miss_address = 16'h4000;
    wait_tags(1, 40, "held_first");
    @(negedge clk);
    checks++;
    if (bus.fsm_busy !== 1'b1 || cyc != t + 13) begin
      errors++;
      $display("FAIL held_reaccept got busy=%b cyc=%0d required busy=1 cyc=%0d", bus.fsm_busy, cyc, t + 13);
    end
    @(posedge clk);
    #2;
    bus.miss_detected = 1'b0;
    wait_tags(2, 40, "held_second");
    checks++;
    if (req_cnt != 16 || wr_cnt != 16 || req_last != t + 21) begin
      errors++;
      $display("FAIL back_to_back got r=%0d w=%0d last_req=%0d required 16/16/%0d", req_cnt, wr_cnt, req_last, t + 21);
    end
    $display("held miss 2000 then 4000 t=%0d", t);
  endtask

  task automatic test_irregular();
    int t;
    irregular = 1;
    clear_stats();
    push_block(16'h8A40);
    issue_miss(16'h8A46, t);
    wait_tags(1, 120, "irregular");
    checks++;
    if (wr_cnt != 8 || tag_cnt != 1 || exp_fill.size() != 0) begin
      errors++;
      $display("FAIL irregular_counts got w=%0d tags=%0d left=%0d required 8/1/0", wr_cnt, tag_cnt, exp_fill.size());
    end
    irregular = 0;
    $display("irregular latency fill miss=8A46 t=%0d", t);
  endtask

  task automatic test_reset_mid_fill();
    int t;
    int base_ret;
    clear_stats();
    push_block(16'h1230);
    base_ret = ret_cnt;
    issue_miss(16'h1234, t);
    for (int i = 0; i < 40; i++) begin
      if (ret_cnt >= base_ret + 3) break;
      @(posedge clk);
      #2;
    end
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_req.delete();
    exp_fill.delete();
    @(negedge clk);
    checks++;
    if ({bus.fsm_busy, bus.memory_enable, bus.write_data_array, bus.write_tag_array} !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_ctrl got %b required 0000", {bus.fsm_busy, bus.memory_enable, bus.write_data_array, bus.write_tag_array});
    end
    checks++;
    if (bus.memory_address !== 16'h0000 || bus.fill_address !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_addr got %h/%h required 0000/0000", bus.memory_address, bus.fill_address);
    end
    checks++;
    if (wr_cnt != 3) begin
      errors++;
      $display("FAIL midrst_writes got %0d required 3", wr_cnt);
    end
    for (int i = 0; i < 40; i++) begin
      if (pend_due.size() == 0) break;
      @(posedge clk);
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (wr_cnt != 3 || pend_due.size() != 0) begin
      errors++;
      $display("FAIL stale_returns got w=%0d pending=%0d required 3/0", wr_cnt, pend_due.size());
    end
    clear_stats();
    push_block(16'h1230);
    issue_miss(16'h1234, t);
    wait_tags(1, 40, "refetch");
    checks++;
    if (wr_cnt != 8 || req_cnt != 8) begin
      errors++;
      $display("FAIL refetch_counts got w=%0d r=%0d required 8/8", wr_cnt, req_cnt);
    end
    $display("reset mid-fill then refetch t=%0d", t);
  endtask

  task automatic test_rst_with_miss();
    clear_stats();
    @(posedge clk);
    #2;
    rst = 1'b1;
    bus.miss_detected = 1'b1;
    bus.miss_address = 16'h5550;
    @(negedge clk);
    checks++;
    if (bus.memory_enable !== 1'b0) begin
      errors++;
      $display("FAIL rstmiss_enable got %b required 0", bus.memory_enable);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    bus.miss_detected = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.fsm_busy !== 1'b0 || bus.memory_enable !== 1'b0) begin
      errors++;
      $display("FAIL rstmiss_idle got busy=%b en=%b required 0/0", bus.fsm_busy, bus.memory_enable);
    end
    repeat (10) @(posedge clk);
    #2;
    checks++;
    if (req_cnt != 0) begin
      errors++;
      $display("FAIL rstmiss_reqs got %0d required 0", req_cnt);
    end
    $display("reset with miss stays idle");
  endtask

  initial begin
    rst = 1'b1;
    bus.miss_detected = 1'b0;
    bus.miss_address = 16'h0000;
    test_reset();
    test_basic_fill();
    repeat (3) @(posedge clk);
    test_top_of_memory();
    repeat (3) @(posedge clk);
    test_miss_held();
    repeat (3) @(posedge clk);
    test_irregular();
    repeat (3) @(posedge clk);
    test_reset_mid_fill();
    repeat (3) @(posedge clk);
    test_rst_with_miss();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
